// File: rtl/chain_input_arbiter.sv
// Round-robin front end for a component chain: shares one value/enable
// input among NUM_REQ requesters with bounded bursts and a registered output.
module chain_input_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ*WIDTH-1:0]   in_value,
  input  logic [NUM_REQ-1:0]         in_enable,
  output logic [NUM_REQ-1:0]         in_ready,
  output logic [WIDTH-1:0]           out_value,
  output logic                       out_enable,
  output logic [NUM_REQ-1:0]         out_grant,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] out_owner
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);
  localparam logic [CW-1:0] MB_C     = CW'(MAX_BURST);

  logic [0:0]        fsm;
  logic [IW-1:0]     owner;
  logic [IW-1:0]     last;
  logic [CW-1:0]     burst_cnt;

  logic [WIDTH-1:0]  vals [NUM_REQ];

  logic              cont;
  logic              found;
  logic [IW-1:0]     win;
  logic [IW-1:0]     sel;
  logic              accept;
  logic              releasing;
  int                base;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign vals[g] = in_value[g*WIDTH +: WIDTH];
  end

  assign releasing = (fsm == HOLD);

  assign cont = (fsm == HOLD)
             && in_enable[owner]
             && (burst_cnt < MB_C);

  // Scan starts just past the reference, so the releasing owner comes last.
  always_comb begin
    logic [IW-1:0] idx;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    base  = (int'(releasing ? owner : last) + 1) % NUM_REQ;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IW'((base + k) % NUM_REQ);
      if (!found && in_enable[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign sel    = cont ? owner : win;
  assign accept = !reset && (cont || found);

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      in_ready[i] = accept && (sel == IW'(i));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm       <= IDLE;
      owner     <= '0;
      last      <= LAST_RST;
      burst_cnt <= '0;
    end else if (cont) begin
      burst_cnt <= burst_cnt + CW'(1);
    end else begin
      if (releasing) begin
        last <= owner;
      end
      if (found) begin
        fsm       <= HOLD;
        owner     <= win;
        burst_cnt <= CW'(1);
      end else begin
        fsm       <= IDLE;
        burst_cnt <= '0;
      end
    end
  end

  // Output stage: value/owner hold on idle cycles, grant clears.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_value  <= '0;
      out_enable <= 1'b0;
      out_grant  <= '0;
      out_owner  <= '0;
    end else begin
      out_enable <= accept;
      out_grant  <= in_ready;
      if (accept) begin
        out_value <= vals[sel];
        out_owner <= sel;
      end
    end
  end

endmodule

// File: tb/tb_chain_input_arbiter.sv
// Directed and random checks of chain_input_arbiter against a
// rotation-distance reference model.
module tb_chain_input_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int MB = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic [N*W-1:0]   in_value;
  logic [N-1:0]     in_enable;
  logic [N-1:0]     in_ready;
  logic [W-1:0]     out_value;
  logic             out_enable;
  logic [N-1:0]     out_grant;
  logic [1:0]       out_owner;

  chain_input_arbiter #(
    .NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_value(in_value),
    .in_enable(in_enable),
    .in_ready(in_ready),
    .out_value(out_value),
    .out_enable(out_enable),
    .out_grant(out_grant),
    .out_owner(out_owner)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] vals [N];

  int          m_hold, m_own, m_last, m_cnt, m_cont;
  logic [W-1:0] m_oval;
  int          m_oen, m_ogr, m_oown;
  int          last_w;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Winner = enabled requester with the smallest rotation distance from base.
  function automatic int pick(input logic [N-1:0] en);
    int base, best, bd, d;
    m_cont = 0;
    if (m_hold != 0 && en[m_own] && m_cnt < MB) begin
      m_cont = 1;
      return m_own;
    end
    base = m_hold != 0 ? (m_own + 1) % N : (m_last + 1) % N;
    best = -1;
    bd   = N;
    for (int i = 0; i < N; i++) begin
      if (en[i]) begin
        d = (i - base + N) % N;
        if (d < bd) begin
          bd   = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  task automatic model_update(input logic rst, input int w);
    if (rst) begin
      m_hold = 0; m_own = 0; m_last = N - 1; m_cnt = 0;
      m_oval = '0; m_oen = 0; m_ogr = 0; m_oown = 0;
      return;
    end
    if (m_cont != 0) begin
      m_cnt++;
    end else begin
      if (m_hold != 0) m_last = m_own;
      if (w >= 0) begin
        m_own = w; m_cnt = 1; m_hold = 1;
      end else begin
        m_hold = 0; m_cnt = 0;
      end
    end
    m_oen = (w >= 0) ? 1 : 0;
    if (w >= 0) begin
      m_oval = vals[w];
      m_ogr  = 1 << w;
      m_oown = w;
    end else begin
      m_ogr = 0;
    end
  endtask

  task automatic cyc(input logic [N-1:0] en, input logic rst);
    int w;
    logic [N-1:0] er;
    reset     = rst;
    in_enable = en;
    for (int i = 0; i < N; i++) in_value[i*W +: W] = vals[i];
    #1;
    w = rst ? -1 : pick(en);
    if (rst) m_cont = 0;
    er = (w < 0) ? '0 : N'(1 << w);
    check("in_ready", 32'(in_ready), 32'(er));
    @(posedge clock);
    #1;
    model_update(rst, w);
    check("out_enable", 32'(out_enable), 32'(m_oen));
    check("out_grant", 32'(out_grant), 32'(m_ogr));
    check("out_value", 32'(out_value), 32'(m_oval));
    if (m_oen != 0)
      check("out_owner", 32'(out_owner), 32'(m_oown));
    last_w = w;
  endtask

  initial begin
    int pulses;
    logic [N-1:0] en;
    m_hold = 0; m_own = 0; m_last = N - 1; m_cnt = 0; m_cont = 0;
    m_oval = '0; m_oen = 0; m_ogr = 0; m_oown = 0;
    for (int i = 0; i < N; i++) vals[i] = '0;
    reset = 1'b1; in_enable = '0; in_value = '0;

    // 1: reset, then everyone requests
    for (int i = 0; i < N; i++) vals[i] = W'(16'h1000 + i);
    for (int k = 0; k < 3; k++) cyc(4'b1111, 1'b1);
    check("rst_out_value", 32'(out_value), 32'h0);
    for (int k = 0; k < 5; k++) begin
      cyc(4'b1111, 1'b0);
      if (k < 4) begin
        check("t1_value", 32'(out_value), 32'h1000);
        check("t1_grant", 32'(out_grant), 32'b0001);
      end else begin
        check("t1_value5", 32'(out_value), 32'h1001);
      end
    end

    // 2: lone requester keeps streaming across burst boundaries
    cyc('0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      vals[2] = W'(16'h20 + k);
      cyc(4'b0100, 1'b0);
      check("t2_ready", 32'(in_ready !== 4'b0100 ? 4'b1111 : 4'b0100), 32'b0100);
      check("t2_en", 32'(out_enable), 32'h1);
      check("t2_val", 32'(out_value), 32'(16'h20 + k));
    end

    // 3: full contention rotates every MAX_BURST words
    cyc('0, 1'b1);
    pulses = 0;
    for (int i = 0; i < N; i++) vals[i] = W'(16'h3000 + i);
    for (int k = 0; k < 17; k++) begin
      cyc(4'b1111, 1'b0);
      if (k < 16 && last_w >= 0) pulses++;
      check("t3_owner", 32'(out_owner), 32'((k / MB) % N));
    end
    check("t3_pulses", 32'(pulses), 32'd16);

    // 4: owner drops mid-burst, requester 3 takes over the same cycle
    cyc('0, 1'b1);
    vals[1] = 16'h4101; vals[3] = 16'h4303;
    cyc(4'b0010, 1'b0);
    cyc(4'b1010, 1'b0);
    cyc(4'b1000, 1'b0);
    check("t4_ready", 32'(last_w), 32'd3);
    check("t4_grant", 32'(out_grant), 32'b1000);
    check("t4_noGap", 32'(out_enable), 32'h1);

    // 5: reset in the middle of owner 2's burst
    cyc('0, 1'b1);
    cyc(4'b0100, 1'b0);
    cyc(4'b0100, 1'b0);
    cyc(4'b1111, 1'b1);
    check("t5_en", 32'(out_enable), 32'h0);
    cyc(4'b1111, 1'b0);
    check("t5_first", 32'(out_grant), 32'b0001);

    // 6: idle period keeps the last word
    vals[1] = 16'hBEEF;
    cyc(4'b0010, 1'b0);
    check("t6_val", 32'(out_value), 32'hBEEF);
    for (int k = 0; k < 5; k++) begin
      cyc('0, 1'b0);
      check("t6_hold", 32'(out_value), 32'hBEEF);
      check("t6_grant0", 32'(out_grant), 32'h0);
    end
    vals[3] = 16'h6303;
    cyc(4'b1000, 1'b0);
    check("t6_imm", 32'(out_grant), 32'b1000);

    // random traffic with occasional reset
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) vals[i] = W'($urandom);
      en = N'($urandom);
      if ($urandom_range(0, 3) == 0) en = 4'b1111;
      cyc(en, ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/chain_input_arbiter.md
Name: chain_input_arbiter

Overview:
- Round-robin arbiter that shares the single value/enable input of a component pipeline chain among NUM_REQ requesters.
- Each requester presents a value/enable pair; one word per cycle is accepted and forwarded through a registered output stage.
- A winner may keep its grant for a bounded burst of back-to-back words. Ownership then rotates without a bubble cycle.
- Sits directly in front of the first chain component; its outputs drive that component's in_value/in_enable.

Parameters:
- NUM_REQ, 4, number of requesters; legal values are 2 or more.
- WIDTH, 16, data width of each value.
- MAX_BURST, 4, maximum consecutive words accepted from one owner before forced release; legal values are 1 or more.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_value  input  NUM_REQ*WIDTH  packed requester values; requester i occupies bits [i*WIDTH +: WIDTH].
- in_enable  input  NUM_REQ  requester i has a valid word this cycle.
- in_ready  output  NUM_REQ  combinational, one-hot or zero; bit i high means requester i's word is accepted this cycle.
- out_value  output  WIDTH  registered forwarded word.
- out_enable  output  1  registered; high for one cycle per accepted word.
- out_grant  output  NUM_REQ  registered one-hot source of the current out_value; zero when out_enable is low.
- out_owner  output  max(1,clog2(NUM_REQ))  registered index of the current burst owner; valid while out_enable is high.

Behaviour:
- Interface: one clock; reset is synchronous and active-high; ports named clock and reset.
- State:
  - fsm is IDLE or HOLD.
  - owner index.
  - last (previous owner) index.
  - burst_cnt, width clog2(MAX_BURST+1).
- Reset values: fsm=IDLE, last=NUM_REQ-1 (so requester 0 has first priority), owner=0, burst_cnt=0, out_value=0, out_enable=0, out_grant=0, out_owner=0.
- Reset takes priority over every other event. in_ready is 0 while reset is high.
- Continue rule: if fsm=HOLD and in_enable[owner]=1 and burst_cnt<MAX_BURST:
  - accept from owner;
  - burst_cnt increments;
  - fsm stays HOLD.
- Otherwise arbitrate:
  - Candidate base is owner+1 mod NUM_REQ if fsm=HOLD (release), else last+1 mod NUM_REQ.
  - Winner is the first i with in_enable[i]=1, scanning base, base+1, ... with wrap-around.
  - The releasing owner is scanned last, so it is still eligible when it is the only requester.
  - Winner found: accept from winner; owner=winner; burst_cnt=1; fsm=HOLD.
  - On release, last=old owner.
  - No winner: fsm=IDLE; last=old owner if releasing; burst_cnt=0.
- MAX_BURST=1: every accepted cycle releases on the following cycle, giving pure per-word round-robin.
- in_ready: exactly the accepted requester's bit is high in the accept cycle. It never asserts for a requester whose in_enable is low.
- Latency: a word accepted in cycle t appears on out_value with out_enable=1 and out_grant/out_owner identifying its source at cycle t+1.
- Cycles with no accept: out_enable=0 and out_grant=0; out_value and out_owner hold their previous values.
- An owner dropping in_enable mid-burst releases in that same cycle; another pending requester is accepted in that cycle (no bubble).
- in_value of non-accepted requesters is ignored. No word is ever duplicated or dropped once in_ready is high.

Test Plan:
1. Reset held 3 cycles, then all in_enable=1111 with value_i=0x1000+i -> cycles 1..4 out_value=0x1000 with out_grant=0001; cycle 5 out_value=0x1001. During reset all outputs are 0.
2. Only requester 2 enabled continuously, values 0x20,0x21,... -> in_ready=0100 every cycle; out_enable continuously 1 from the second cycle; out_value follows input with 1-cycle delay; no gap at the burst boundary.
3. All four continuously enabled, MAX_BURST=4 -> out_owner sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0; exactly 16 in_ready pulses per 16 cycles.
4. Requester 1 owns the grant, sends 2 words, then drops in_enable while requester 3 is enabled -> in_ready[3]=1 in the drop cycle; next out_grant=1000; no out_enable gap.
5. Reset asserted mid-burst (owner 2, burst_cnt=2) with all enabled -> next cycle out_enable=0; after release requester 0 wins first.
6. No requests for 5 cycles after out_value=0xBEEF -> out_enable=0, out_grant=0, out_value stays 0xBEEF; fsm returns to IDLE; next single request from requester 3 is granted immediately.
